// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the 64x4 RAM: grants one requester at a time, issues a single RAM access, returns ack/rdata.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins); default is round-robin.
module ram_arbiter #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_enable,
    output logic              ram_readwrite,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout
);

    // state   | meaning
    // IDLE    | waiting for a request; arbitrate and latch the winner's command
    // ISSUE   | RAM enabled for one cycle with the latched command
    // CAPTURE | read only: register ram_dataout into the granted port's rdata
    // ACK     | one-cycle ack to the granted port
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t state, state_next;
    logic   grant;
    logic   win1;
    logic   take;

`ifndef ARB_FIXED_PRIO_EN
    logic last_grant;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        win1 = req1 && !req0;
`else
        win1 = req1 && (!req0 || !last_grant);
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = ISSUE;
                    take       = 1'b1;
                end
            end
            ISSUE:   state_next = ram_readwrite ? ACK : CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The RAM pin registers double as the command registers, so they hold outside ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant         <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            busy          <= 1'b0;
            ram_enable    <= 1'b0;
            ram_readwrite <= 1'b0;
            ram_address   <= '0;
            ram_datain    <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant    <= 1'b1;
`endif
        end else begin
            ram_enable <= (state_next == ISSUE);
            busy       <= (state_next != IDLE);
            ack0       <= (state_next == ACK) && !grant;
            ack1       <= (state_next == ACK) && grant;
            if (take) begin
                grant         <= win1;
                ram_readwrite <= win1 ? we1 : we0;
                ram_address   <= win1 ? addr1 : addr0;
                ram_datain    <= win1 ? wdata1 : wdata0;
            end
            if (state == CAPTURE) begin
                if (grant) rdata1 <= ram_dataout;
                else       rdata0 <= ram_dataout;
            end
`ifndef ARB_FIXED_PRIO_EN
            if (state == ACK) last_grant <= grant;
`endif
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 64x4 RAM attached.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [5:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [3:0] rdata0, rdata1;
    logic       ram_enable, ram_readwrite;
    logic [5:0] ram_address;
    logic [3:0] ram_datain;
    logic [3:0] ram_dataout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] mem [64];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ram_enable(ram_enable), .ram_readwrite(ram_readwrite),
        .ram_address(ram_address), .ram_datain(ram_datain), .ram_dataout(ram_dataout)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
        ram_dataout = 4'h0;
    end

    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_readwrite) mem[ram_address] <= ram_datain;
            else               ram_dataout <= mem[ram_address];
        end
    end

    // Drives one request at an IDLE-phase negedge, holds it until ack, then leaves one idle cycle.
    task automatic do_access(input bit port, input logic we, input logic [5:0] addr, input logic [3:0] wd,
                             output int lat, output int en_cnt, output logic en_rw,
                             output logic [5:0] en_addr, output logic [3:0] en_din,
                             output logic other_ack, output logic [3:0] rd, output logic busy_at_en);
        lat = -1; en_cnt = 0; en_rw = 1'b0; en_addr = '0; en_din = '0; other_ack = 1'b0; rd = '0;
        busy_at_en = 1'b0;
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
        else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ram_enable) begin
                en_cnt++; en_rw = ram_readwrite; en_addr = ram_address; en_din = ram_datain;
                busy_at_en = busy;
            end
            if (port ? ack0 : ack1) other_ack = 1'b1;
            if (port ? ack1 : ack0) begin
                lat = c;
                rd  = port ? rdata1 : rdata0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
        addr0 = 6'h15; addr1 = 6'h2B; wdata0 = 4'h3; wdata1 = 4'hE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ram_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b expected 0", ram_enable); end
        end
        n_cmp++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ack_busy: got %b expected 000", {ack0, ack1, busy});
        end
        n_cmp++;
        if ({rdata0, rdata1} !== 8'h00) begin
            n_bad++; $display("FAIL reset_rdata: got %h expected 00", {rdata0, rdata1});
        end
        n_cmp++;
        if ({ram_readwrite, ram_address, ram_datain} !== 11'h000) begin
            n_bad++; $display("FAIL reset_ram_pins: got %h expected 000", {ram_readwrite, ram_address, ram_datain});
        end
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, ram_enable} !== 2'b00) begin n_bad++; $display("FAIL reset_release_idle: got %b expected 00", {busy, ram_enable}); end
    endtask

    task automatic test_single_write();
        int lat, en_cnt; logic rw, oth, bz; logic [5:0] a; logic [3:0] d, rd;
        do_access(1'b0, 1'b1, 6'h2A, 4'h5, lat, en_cnt, rw, a, d, oth, rd, bz);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL write_latency: got %0d expected 2", lat); end
        n_cmp++;
        if (en_cnt !== 1) begin n_bad++; $display("FAIL write_enable_cycles: got %0d expected 1", en_cnt); end
        n_cmp++;
        if ({rw, a, d} !== {1'b1, 6'h2A, 4'h5}) begin
            n_bad++; $display("FAIL write_pins: got rw=%b addr=%h din=%h expected rw=1 addr=2a din=5", rw, a, d);
        end
        n_cmp++;
        if (oth !== 1'b0) begin n_bad++; $display("FAIL write_other_ack: got %b expected 0", oth); end
        n_cmp++;
        if (bz !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b expected 1", bz); end
        n_cmp++;
        if ({busy, ram_enable, ram_address, ram_datain} !== {2'b00, 6'h2A, 4'h5}) begin
            n_bad++; $display("FAIL write_idle_hold: got busy=%b en=%b addr=%h din=%h expected 0 0 2a 5",
                              busy, ram_enable, ram_address, ram_datain);
        end
        do_access(1'b0, 1'b1, 6'h00, 4'h7, lat, en_cnt, rw, a, d, oth, rd, bz);
        n_cmp++;
        if ({lat == 2, a, d} !== {1'b1, 6'h00, 4'h7}) begin
            n_bad++; $display("FAIL write_addr0: got lat=%0d addr=%h din=%h expected 2 00 7", lat, a, d);
        end
    endtask

    task automatic test_write_readback();
        int lat, en_cnt; logic rw, oth, bz; logic [5:0] a; logic [3:0] d, rd;
        do_access(1'b1, 1'b1, 6'h3F, 4'hC, lat, en_cnt, rw, a, d, oth, rd, bz);
        n_cmp++;
        if ({lat == 2, rw, a, d} !== {2'b11, 6'h3F, 4'hC}) begin
            n_bad++; $display("FAIL p1_write: got lat=%0d rw=%b addr=%h din=%h expected 2 1 3f c", lat, rw, a, d);
        end
        do_access(1'b1, 1'b0, 6'h3F, 4'h0, lat, en_cnt, rw, a, d, oth, rd, bz);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL read_latency: got %0d expected 3", lat); end
        n_cmp++;
        if ({rw, a, en_cnt == 1} !== {1'b0, 6'h3F, 1'b1}) begin
            n_bad++; $display("FAIL read_pins: got rw=%b addr=%h en_cycles=%0d expected 0 3f 1", rw, a, en_cnt);
        end
        n_cmp++;
        if (rd !== 4'hC) begin n_bad++; $display("FAIL read_data: got %h expected c", rd); end
        n_cmp++;
        if ({rdata1, rdata0} !== 8'hC0) begin
            n_bad++; $display("FAIL rdata_hold: got rdata1=%h rdata0=%h expected c 0", rdata1, rdata0);
        end
        n_cmp++;
        if (oth !== 1'b0) begin n_bad++; $display("FAIL read_other_ack: got %b expected 0", oth); end
    endtask

    task automatic test_contention();
        int  exp_cyc [4];
        bit  exp_port [4];
        int  got_cyc [4];
        bit  got_port [4];
        logic [3:0] got_rd [4];
        int  k = 0;
        logic both = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        exp_cyc = '{3, 7, 11, 15}; exp_port = '{0, 0, 0, 0};
`else
        exp_cyc = '{3, 6, 10, 13}; exp_port = '{0, 1, 0, 1};
`endif
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'h00; wdata0 = 4'h0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'h01; wdata1 = 4'h9;
        for (int c = 1; c <= 30 && k < 4; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both = 1'b1;
            if (ack0 || ack1) begin
                got_port[k] = ack1; got_cyc[k] = c; got_rd[k] = rdata0;
                k++;
                if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (k !== 4) begin n_bad++; $display("FAIL contention_grants: got %0d expected 4", k); end
        n_cmp++;
        if (both !== 1'b0) begin n_bad++; $display("FAIL contention_dual_ack: got %b expected 0", both); end
        for (int i = 0; i < k; i++) begin
            n_cmp++;
            if (got_port[i] !== exp_port[i] || got_cyc[i] !== exp_cyc[i]) begin
                n_bad++; $display("FAIL contention_grant%0d: got port %0d at cycle %0d expected port %0d at cycle %0d",
                                  i, got_port[i], got_cyc[i], exp_port[i], exp_cyc[i]);
            end
            if (!got_port[i]) begin
                n_cmp++;
                if (got_rd[i] !== 4'h7) begin n_bad++; $display("FAIL contention_rdata%0d: got %h expected 7", i, got_rd[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int lat, en_cnt; logic rw, oth, bz; logic [5:0] a; logic [3:0] d, rd;
        logic stray = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'h00;
        @(negedge clk);
        n_cmp++;
        if (ram_enable !== 1'b1) begin n_bad++; $display("FAIL midread_issue: got %b expected 1", ram_enable); end
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ack0, busy, ram_enable} !== 3'b000) begin
            n_bad++; $display("FAIL midread_abort: got ack/busy/en %b expected 000", {ack0, busy, ram_enable});
        end
        n_cmp++;
        if ({rdata0, ram_address} !== 10'h000) begin
            n_bad++; $display("FAIL midread_regs: got rdata0=%h addr=%h expected 0 00", rdata0, ram_address);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack0 || ack1 || ram_enable) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin n_bad++; $display("FAIL midread_stray: got %b expected 0", stray); end
        do_access(1'b0, 1'b0, 6'h2A, 4'h0, lat, en_cnt, rw, a, d, oth, rd, bz);
        n_cmp++;
        if (lat !== 3 || rd !== 4'h5) begin
            n_bad++; $display("FAIL midread_recover: got lat=%0d data=%h expected 3 5", lat, rd);
        end
    endtask

    task automatic run_held(input logic we, input int exp1, input int exp2, input logic [3:0] exp_rd, input string nm);
        int acks [2];
        logic [3:0] rd2 = 4'h0;
        int k = 0;
        int en = 0;
        req0 = 1'b1; we0 = we; addr0 = 6'h10; wdata0 = 4'hA;
        for (int c = 1; c <= 20 && k < 2; c++) begin
            @(negedge clk);
            if (ram_enable) en++;
            if (ack0) begin
                acks[k] = c; k++;
                rd2 = rdata0;
                if (k == 2) req0 = 1'b0;
            end
        end
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (k !== 2 || acks[0] !== exp1 || acks[1] !== exp2) begin
            n_bad++; $display("FAIL %s_acks: got %0d acks at %0d,%0d expected 2 at %0d,%0d", nm, k, acks[0], acks[1], exp1, exp2);
        end
        n_cmp++;
        if (en !== 2 || rd2 !== exp_rd) begin
            n_bad++; $display("FAIL %s_en_data: got en=%0d rdata0=%h expected 2 %h", nm, en, rd2, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        run_held(1'b1, 2, 5, 4'h5, "held_write");
        n_cmp++;
        if (mem[16] !== 4'hA) begin n_bad++; $display("FAIL held_write_mem: got %h expected a", mem[16]); end
        run_held(1'b0, 3, 7, 4'hA, "held_read");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_readback();
        test_contention();
        test_reset_mid_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
